coherence_bus_ctrl: RTL and testbench

- Responder side of the caches_if data/coherence protocol: serves two dcaches (core 0, core 1) and one shared RAM port.
- Arbitrates requests, snoops the non-requesting cache, performs cache-to-cache transfers with memory update, broadcasts invalidations and streams two-word blocks to and from RAM.
- Sits between both dcaches and the memory controller.

---
 rtl/coherence_bus_ctrl_if.sv | 33 +++
 rtl/coherence_bus_ctrl.sv | 177 +++++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/coherence_bus_ctrl_if.sv
// Bus bundle between the two dcaches, the coherence controller and the RAM port.
// Modport slave is the controller; modport master is the cache/RAM side driving it.
interface coherence_bus_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [1:0]             dREN;
  logic [1:0]             dWEN;
  logic [1:0]             ccwrite;
  logic [1:0][ADDR_W-1:0] daddr;
  logic [1:0][DATA_W-1:0] dstore;
  logic [1:0]             dwait;
  logic [1:0][DATA_W-1:0] dload;
  logic [1:0]             ccwait;
  logic [1:0]             ccinv;
  logic [1:0][ADDR_W-1:0] ccsnoopaddr;
  logic                   ramREN;
  logic                   ramWEN;
  logic [ADDR_W-1:0]      ramaddr;
  logic [DATA_W-1:0]      ramstore;
  logic [DATA_W-1:0]      ramload;
  logic                   ramwait;

  modport slave (
    input  dREN, dWEN, ccwrite, daddr, dstore, ramload, ramwait,
    output dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output dREN, dWEN, ccwrite, daddr, dstore, ramload, ramwait,
    input  dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// Two-cache coherence bus controller: round-robin arbitration, snoop of the other
// cache, cache-to-cache transfer with memory update, invalidation broadcast and
// two-word block streaming to/from RAM.
// Optional macro COHERENCE_BUS_STATS_EN adds stat_c2c/stat_inv/stat_memrd counters.
module coherence_bus_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                CLK,
  input  logic                RST,
  coherence_bus_ctrl_if.slave bus
`ifdef COHERENCE_BUS_STATS_EN
  ,
  output logic [31:0]         stat_c2c,
  output logic [31:0]         stat_inv,
  output logic [31:0]         stat_memrd
`endif
);

  typedef enum logic [3:0] {
    StIdle, StWb0, StWb1, StSnoop, StMem0, StMem1, StC2c0, StC2c1, StInv
  } state_e;

  state_e state_q, state_d;
  logic   r_q, r_d;        // current requester
  logic   last_q, last_d;  // last granted cache, for round-robin ties
  logic   o_idx;
  logic   grant;
  logic [1:0] req;

  logic [1:0]             dwait;
  logic [1:0][DATA_W-1:0] dload;
  logic [1:0]             ccwait;
  logic [1:0]             ccinv;
  logic [1:0][ADDR_W-1:0] snoop;
  logic                   ram_ren;
  logic                   ram_wen;
  logic [ADDR_W-1:0]      ram_addr;
  logic [DATA_W-1:0]      ram_store;

  assign o_idx = ~r_q;
  assign req   = bus.dREN | bus.dWEN | bus.ccwrite;

  // State, requester and round-robin registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      r_q     <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      last_q  <= last_d;
    end
  end

  // Next-state: arbitration in idle, word-completion driven progress elsewhere
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    last_d  = last_q;
    grant   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant  = (&req) ? ~last_q : req[1];
          r_d    = grant;
          last_d = grant;
          if (bus.dWEN[grant])      state_d = StWb0;
          else if (bus.dREN[grant]) state_d = StSnoop;
          else                      state_d = StInv;
        end
      end
      StWb0:   if (!bus.ramwait) state_d = StWb1;
      StWb1:   if (!bus.ramwait) state_d = StIdle;
      StSnoop: state_d = bus.ccwrite[o_idx] ? StC2c0 : StMem0;
      StMem0:  if (!bus.ramwait) state_d = StMem1;
      StMem1:  if (!bus.ramwait) state_d = StIdle;
      StC2c0:  if (!bus.ramwait) state_d = StC2c1;
      StC2c1:  if (!bus.ramwait) state_d = StIdle;
      StInv:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; forced to idle values while reset is asserted so no strobe leaks
  always_comb begin
    dwait     = 2'b11;
    dload     = '0;
    ccwait    = 2'b00;
    ccinv     = 2'b00;
    snoop     = '0;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    if (!RST) begin
      unique case (state_q)
        StWb0, StWb1: begin
          ram_wen   = 1'b1;
          ram_addr  = bus.daddr[r_q];
          ram_store = bus.dstore[r_q];
          if (!bus.ramwait) dwait[r_q] = 1'b0;
        end
        StSnoop: begin
          ccwait[o_idx] = 1'b1;
          snoop[o_idx]  = bus.daddr[r_q];
        end
        StMem0, StMem1: begin
          ccwait[o_idx] = 1'b1;
          ram_ren       = 1'b1;
          ram_addr      = bus.daddr[r_q];
          dload[r_q]    = bus.ramload;
          if (!bus.ramwait) dwait[r_q] = 1'b0;
        end
        StC2c0, StC2c1: begin
          ccwait[o_idx] = 1'b1;
          snoop[o_idx]  = bus.daddr[r_q];
          ram_wen       = 1'b1;
          ram_addr      = bus.daddr[o_idx];
          ram_store     = bus.dstore[o_idx];
          dload[r_q]    = bus.dstore[o_idx];
          if (!bus.ramwait) dwait = 2'b00;
        end
        StInv: begin
          ccwait[o_idx] = 1'b1;
          ccinv[o_idx]  = 1'b1;
          snoop[o_idx]  = bus.daddr[r_q];
          dwait[r_q]    = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.dwait       = dwait;
  assign bus.dload       = dload;
  assign bus.ccwait      = ccwait;
  assign bus.ccinv       = ccinv;
  assign bus.ccsnoopaddr = snoop;
  assign bus.ramREN      = ram_ren;
  assign bus.ramWEN      = ram_wen;
  assign bus.ramaddr     = ram_addr;
  assign bus.ramstore    = ram_store;

`ifdef COHERENCE_BUS_STATS_EN
  logic [31:0] c2c_q, c2c_d, inv_q, inv_d, memrd_q, memrd_d;

  // Event counters; C2C0 and MEM0 are only ever entered from SNOOP
  always_comb begin
    c2c_d   = c2c_q;
    inv_d   = inv_q;
    memrd_d = memrd_q;
    if (state_q == StSnoop && state_d == StC2c0) c2c_d   = c2c_q + 32'd1;
    if (state_q == StSnoop && state_d == StMem0) memrd_d = memrd_q + 32'd1;
    if (state_q == StInv)                        inv_d   = inv_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      c2c_q   <= '0;
      inv_q   <= '0;
      memrd_q <= '0;
    end else begin
      c2c_q   <= c2c_d;
      inv_q   <= inv_d;
      memrd_q <= memrd_d;
    end
  end

  assign stat_c2c   = c2c_q;
  assign stat_inv   = inv_q;
  assign stat_memrd = memrd_q;
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: per-cycle vector table plus hand-written
// round-robin and mid-transaction reset sequences.
module tb_coherence_bus_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  coherence_bus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef COHERENCE_BUS_STATS_EN
  logic [31:0] stat_c2c, stat_inv, stat_memrd;
`endif

  coherence_bus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
`ifdef COHERENCE_BUS_STATS_EN
    ,
    .stat_c2c   (stat_c2c),
    .stat_inv   (stat_inv),
    .stat_memrd (stat_memrd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [1:0]  dren, dwen, ccw;
    logic [31:0] a0, a1, s0, s1, rl;
    logic        rw;
    logic [1:0]  e_dw;
    logic [31:0] e_dl0, e_dl1;
    logic [1:0]  e_cw, e_ci;
    logic [31:0] e_sa0, e_sa1;
    logic        e_rr, e_rwn;
    logic [31:0] e_ra, e_rs;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input string n, input logic r, input logic [1:0] dren, input logic [1:0] dwen,
    input logic [1:0] ccw, input logic [31:0] a0, input logic [31:0] a1,
    input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] rl, input logic rw,
    input logic [1:0] e_dw, input logic [31:0] e_dl0, input logic [31:0] e_dl1,
    input logic [1:0] e_cw, input logic [1:0] e_ci, input logic [31:0] e_sa0,
    input logic [31:0] e_sa1, input logic e_rr, input logic e_rwn,
    input logic [31:0] e_ra, input logic [31:0] e_rs);
    vec_t v;
    v.name = n; v.rst = r; v.dren = dren; v.dwen = dwen; v.ccw = ccw;
    v.a0 = a0; v.a1 = a1; v.s0 = s0; v.s1 = s1; v.rl = rl; v.rw = rw;
    v.e_dw = e_dw; v.e_dl0 = e_dl0; v.e_dl1 = e_dl1; v.e_cw = e_cw; v.e_ci = e_ci;
    v.e_sa0 = e_sa0; v.e_sa1 = e_sa1; v.e_rr = e_rr; v.e_rwn = e_rwn;
    v.e_ra = e_ra; v.e_rs = e_rs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; outputs settle before the next rise
  task automatic drive(input logic r, input logic [1:0] dren, input logic [1:0] dwen,
                       input logic [1:0] ccw, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] s0, input logic [31:0] s1,
                       input logic [31:0] rl, input logic rw);
    @(negedge clk);
    rst          = r;
    bus.dREN     = dren;
    bus.dWEN     = dwen;
    bus.ccwrite  = ccw;
    bus.daddr[0] = a0;
    bus.daddr[1] = a1;
    bus.dstore[0] = s0;
    bus.dstore[1] = s1;
    bus.ramload  = rl;
    bus.ramwait  = rw;
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    string p;
    drive(v.rst, v.dren, v.dwen, v.ccw, v.a0, v.a1, v.s0, v.s1, v.rl, v.rw);
    p = $sformatf("%s[%0d]", v.name, idx);
    chk({p, ".dwait"},    64'(bus.dwait),          64'(v.e_dw));
    chk({p, ".dload0"},   64'(bus.dload[0]),       64'(v.e_dl0));
    chk({p, ".dload1"},   64'(bus.dload[1]),       64'(v.e_dl1));
    chk({p, ".ccwait"},   64'(bus.ccwait),         64'(v.e_cw));
    chk({p, ".ccinv"},    64'(bus.ccinv),          64'(v.e_ci));
    chk({p, ".snoop0"},   64'(bus.ccsnoopaddr[0]), 64'(v.e_sa0));
    chk({p, ".snoop1"},   64'(bus.ccsnoopaddr[1]), 64'(v.e_sa1));
    chk({p, ".ramREN"},   64'(bus.ramREN),         64'(v.e_rr));
    chk({p, ".ramWEN"},   64'(bus.ramWEN),         64'(v.e_rwn));
    chk({p, ".ramaddr"},  64'(bus.ramaddr),        64'(v.e_ra));
    chk({p, ".ramstore"}, 64'(bus.ramstore),       64'(v.e_rs));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.dREN = '0; bus.dWEN = '0; bus.ccwrite = '0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramwait = 1'b0;

    // name, rst, dren, dwen, ccw, a0, a1, s0, s1, rl, rw |
    //   dwait, dl0, dl1, ccwait, ccinv, sa0, sa1, ramREN, ramWEN, ramaddr, ramstore
    vecs.push_back(mk("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // cache 0 fill from memory
    vecs.push_back(mk("rd_idle", 0, 2'b01, 0, 0, 'h100, 0, 0, 0, 0, 0,
                      2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rd_snoop", 0, 2'b01, 0, 0, 'h100, 0, 0, 0, 0, 0,
                      2'b11, 0, 0, 2'b10, 0, 0, 'h100, 0, 0, 0, 0));
    vecs.push_back(mk("rd_w0", 0, 2'b01, 0, 0, 'h100, 0, 0, 0, 'hAAAA, 0,
                      2'b10, 'hAAAA, 0, 2'b10, 0, 0, 0, 1, 0, 'h100, 0));
    vecs.push_back(mk("rd_w1", 0, 2'b01, 0, 0, 'h104, 0, 0, 0, 'hBBBB, 0,
                      2'b10, 'hBBBB, 0, 2'b10, 0, 0, 0, 1, 0, 'h104, 0));
    vecs.push_back(mk("rd_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // cache 1 fill served by cache 0 holding the block in M
    vecs.push_back(mk("c2c_idle", 0, 2'b10, 0, 0, 0, 'h200, 0, 0, 0, 0,
                      2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("c2c_snoop", 0, 2'b10, 0, 2'b01, 0, 'h200, 0, 0, 0, 0,
                      2'b11, 0, 0, 2'b01, 0, 'h200, 0, 0, 0, 0, 0));
    vecs.push_back(mk("c2c_w0", 0, 2'b10, 0, 2'b01, 'h200, 'h200, 'h11, 0, 0, 0,
                      2'b00, 0, 'h11, 2'b01, 0, 'h200, 0, 0, 1, 'h200, 'h11));
    vecs.push_back(mk("c2c_w1", 0, 2'b10, 0, 2'b01, 'h204, 'h204, 'h22, 0, 0, 0,
                      2'b00, 0, 'h22, 2'b01, 0, 'h204, 0, 0, 1, 'h204, 'h22));
    vecs.push_back(mk("c2c_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // cache 0 upgrade -> invalidate cache 1
    vecs.push_back(mk("inv_idle", 0, 0, 0, 2'b01, 'h308, 0, 0, 0, 0, 0,
                      2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("inv", 0, 0, 0, 2'b01, 'h308, 0, 0, 0, 0, 0,
                      2'b10, 0, 0, 2'b10, 2'b10, 0, 'h308, 0, 0, 0, 0));
    vecs.push_back(mk("inv_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // cache 0 writeback with RAM stall
    vecs.push_back(mk("wb_idle", 0, 0, 2'b01, 0, 'h400, 0, 'hDEAD, 0, 0, 1,
                      2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("wb_stall", 0, 0, 2'b01, 0, 'h400, 0, 'hDEAD, 0, 0, 1,
                      2'b11, 0, 0, 0, 0, 0, 0, 0, 1, 'h400, 'hDEAD));
    vecs.push_back(mk("wb_stall", 0, 0, 2'b01, 0, 'h400, 0, 'hDEAD, 0, 0, 1,
                      2'b11, 0, 0, 0, 0, 0, 0, 0, 1, 'h400, 'hDEAD));
    vecs.push_back(mk("wb_w0", 0, 0, 2'b01, 0, 'h400, 0, 'hDEAD, 0, 0, 0,
                      2'b10, 0, 0, 0, 0, 0, 0, 0, 1, 'h400, 'hDEAD));
    vecs.push_back(mk("wb_w1", 0, 0, 2'b01, 0, 'h404, 0, 'hBEEF, 0, 0, 0,
                      2'b10, 0, 0, 0, 0, 0, 0, 0, 1, 'h404, 'hBEEF));
    vecs.push_back(mk("wb_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) apply(vecs[i], i);

    // Round-robin: tie after reset goes to cache 0, then cache 1, then cache 0 again
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 2'b11, 0, 0, 'h500, 'h600, 0, 0, 0, 0);
    drive(0, 2'b11, 0, 0, 'h500, 'h600, 0, 0, 0, 0);
    chk("rr1.ccwait", 64'(bus.ccwait), 64'(2'b10));
    chk("rr1.snoop1", 64'(bus.ccsnoopaddr[1]), 64'h500);
    drive(0, 2'b11, 0, 0, 'h500, 'h600, 0, 0, 'h1, 0);
    chk("rr1.dwait0", 64'(bus.dwait), 64'(2'b10));
    drive(0, 2'b11, 0, 0, 'h504, 'h600, 0, 0, 'h2, 0);
    chk("rr1.dwait1", 64'(bus.dwait), 64'(2'b10));
    drive(0, 2'b10, 0, 0, 0, 'h600, 0, 0, 0, 0);
    drive(0, 2'b10, 0, 0, 0, 'h600, 0, 0, 0, 0);
    chk("rr2.ccwait", 64'(bus.ccwait), 64'(2'b01));
    chk("rr2.snoop0", 64'(bus.ccsnoopaddr[0]), 64'h600);
    drive(0, 2'b10, 0, 0, 0, 'h600, 0, 0, 'h3, 0);
    chk("rr2.dwait0", 64'(bus.dwait), 64'(2'b01));
    chk("rr2.dload1", 64'(bus.dload[1]), 64'h3);
    drive(0, 2'b10, 0, 0, 0, 'h604, 0, 0, 'h4, 0);
    chk("rr2.dwait1", 64'(bus.dwait), 64'(2'b01));
    drive(0, 2'b11, 0, 0, 'h500, 'h600, 0, 0, 0, 0);
    drive(0, 2'b11, 0, 0, 'h500, 'h600, 0, 0, 0, 0);
    chk("rr3.ccwait", 64'(bus.ccwait), 64'(2'b10));
    chk("rr3.snoop1", 64'(bus.ccsnoopaddr[1]), 64'h500);

    // Reset asserted while in MEM1 aborts the fill
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 2'b01, 0, 0, 'h700, 0, 0, 0, 0, 0);
    drive(0, 2'b01, 0, 0, 'h700, 0, 0, 0, 0, 0);
    drive(0, 2'b01, 0, 0, 'h700, 0, 0, 0, 'h5, 0);
    chk("rst.mem0_ren", 64'(bus.ramREN), 64'h1);
    drive(1, 2'b01, 0, 0, 'h704, 0, 0, 0, 'h6, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst.dwait", 64'(bus.dwait), 64'(2'b11));
    chk("rst.ramREN", 64'(bus.ramREN), 64'h0);
    chk("rst.ramWEN", 64'(bus.ramWEN), 64'h0);
    chk("rst.ccwait", 64'(bus.ccwait), 64'h0);
    drive(0, 2'b10, 0, 0, 0, 'h800, 0, 0, 0, 0);
    drive(0, 2'b10, 0, 0, 0, 'h800, 0, 0, 0, 0);
    chk("rst.regrant", 64'(bus.ccwait), 64'(2'b01));
    chk("rst.snoop0", 64'(bus.ccsnoopaddr[0]), 64'h800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
